// File: rtl/conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_scheduler
// Purpose  : Runs one conv layer by driving the per-output-group conv
//            controller once per output group. For each group it sets the
//            group's weight base address, rewinds the input stream, pulses
//            go, waits for done, then requests output writeback.
// Options  : `define CONV_SCHED_PERF_EN adds the perf_cycles and
//            perf_wb_stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_scheduler #(
  parameter int WT_ADDR_WIDTH   = 12,
  parameter int BIAS_ADDR_WIDTH = 7,
  parameter int CI_WIDTH        = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CI_WIDTH-1:0]        cfg_ci_groups,
  input  logic [BIAS_ADDR_WIDTH:0]   cfg_co_groups,
  input  logic [WT_ADDR_WIDTH-1:0]   cfg_wt_base,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic                       cc_go,
  output logic [CI_WIDTH-1:0]        cc_ci_groups,
  output logic [BIAS_ADDR_WIDTH-1:0] cc_output_group,
  output logic [WT_ADDR_WIDTH-1:0]   cc_wt_base_addr,
  input  logic                       cc_busy,
  input  logic                       cc_done,
  output logic                       in_rewind,
  input  logic                       in_rewind_ack,
  output logic                       wb_req,
  input  logic                       wb_ack
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_cycles,
  output logic [31:0]                perf_wb_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_REWIND = 3'd2,
    S_LAUNCH = 3'd3,
    S_RUN    = 3'd4,
    S_WB     = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  // Largest legal group count is 2^BIAS_ADDR_WIDTH.
  localparam logic [BIAS_ADDR_WIDTH:0] CO_MAX = {1'b1, {BIAS_ADDR_WIDTH{1'b0}}};
  localparam logic [BIAS_ADDR_WIDTH:0] CO_ONE = {{BIAS_ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [BIAS_ADDR_WIDTH-1:0] og_q, og_d;
  logic [WT_ADDR_WIDTH-1:0]   acc_q, acc_d;
  logic [CI_WIDTH-1:0]        ci_q, ci_d;
  logic [BIAS_ADDR_WIDTH:0]   co_q, co_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       cfg_illegal;
  logic                       last_group;

  assign cfg_illegal = (cfg_ci_groups == '0) || (cfg_co_groups == '0) ||
                       (cfg_co_groups > CO_MAX);
  assign last_group  = ({1'b0, og_q} == (co_q - CO_ONE));

  // Group index and address accumulator double as the controller-facing
  // outputs, so they only move on start and on the WB->SETUP step.
  assign busy            = (state_q != S_IDLE);
  assign cfg_err         = cfg_err_q;
  assign cc_ci_groups    = ci_q;
  assign cc_output_group = og_q;
  assign cc_wt_base_addr = acc_q;

  // Next-state and pulse outputs; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    og_d      = og_q;
    acc_d     = acc_q;
    ci_d      = ci_q;
    co_d      = co_q;
    cfg_err_d = cfg_err_q;
    cc_go     = 1'b0;
    in_rewind = 1'b0;
    wb_req    = 1'b0;
    done      = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_err_d = cfg_illegal;
            if (cfg_illegal) begin
              // Bad config: skip straight to the done pulse.
              state_d = S_FIN;
            end else begin
              state_d = S_SETUP;
              og_d    = '0;
              acc_d   = cfg_wt_base;
              ci_d    = cfg_ci_groups;
              co_d    = cfg_co_groups;
            end
          end
        end
        S_SETUP: begin
          in_rewind = 1'b1;
          state_d   = S_REWIND;
        end
        S_REWIND: begin
          if (in_rewind_ack) state_d = S_LAUNCH;
        end
        S_LAUNCH: begin
          if (!cc_busy) begin
            cc_go   = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (cc_done) state_d = S_WB;
        end
        S_WB: begin
          wb_req = 1'b1;
          if (wb_ack) begin
            if (last_group) begin
              state_d = S_FIN;
            end else begin
              state_d = S_SETUP;
              og_d    = og_q + BIAS_ADDR_WIDTH'(1);
              // Incremental address: wraps modulo the weight address space.
              acc_d   = acc_q + WT_ADDR_WIDTH'(ci_q);
            end
          end
        end
        S_FIN: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and latched-config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      og_q      <= '0;
      acc_q     <= '0;
      ci_q      <= '0;
      co_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      og_q      <= og_d;
      acc_q     <= acc_d;
      ci_q      <= ci_d;
      co_q      <= co_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_wb_stall_q, perf_wb_stall_d;

  assign perf_cycles   = perf_cycles_q;
  assign perf_wb_stall = perf_wb_stall_q;

  // Saturating counters, cleared on every accepted start.
  always_comb begin
    perf_cycles_d   = perf_cycles_q;
    perf_wb_stall_d = perf_wb_stall_q;
    if ((state_q == S_IDLE) && start) begin
      perf_cycles_d   = '0;
      perf_wb_stall_d = '0;
    end else begin
      if (busy && (perf_cycles_q != '1))
        perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == S_WB) && !wb_ack && (perf_wb_stall_q != '1))
        perf_wb_stall_d = perf_wb_stall_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q   <= '0;
      perf_wb_stall_q <= '0;
    end else begin
      perf_cycles_q   <= perf_cycles_d;
      perf_wb_stall_q <= perf_wb_stall_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Sequences one full conv layer by running the per-output-group conv controller once per output group.
- Each group pass: computes the group's weight base address, rewinds the input feature-map stream, pulses go, waits for done, then hands off to output writeback.
- Sits between the CPU layer-config registers and conv_controller / input DMA / output writeback.

Parameters:
- WT_ADDR_WIDTH, 12, width of weight BRAM address.
- BIAS_ADDR_WIDTH, 7, width of output-group index.
- CI_WIDTH, 10, width of input-channel-group count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch layer; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after rst.
- cfg_ci_groups  in  CI_WIDTH  input channel groups per output group.
- cfg_co_groups  in  BIAS_ADDR_WIDTH+1  number of output groups (1..2^BIAS_ADDR_WIDTH).
- cfg_wt_base  in  WT_ADDR_WIDTH  layer weight base address.
- busy  out  1  high from accepted start until done/abort.
- done  out  1  one-cycle pulse at layer end.
- cfg_err  out  1  sticky until next start; set on illegal config.
- cc_go  out  1  one-cycle go pulse to conv controller.
- cc_ci_groups  out  CI_WIDTH  latched cfg_ci_groups.
- cc_output_group  out  BIAS_ADDR_WIDTH  current output group.
- cc_wt_base_addr  out  WT_ADDR_WIDTH  weight base for current group.
- cc_busy  in  1  conv controller busy.
- cc_done  in  1  conv controller done pulse.
- in_rewind  out  1  one-cycle pulse restarting the input stream at pixel 0.
- in_rewind_ack  in  1  input stream ready for the current group.
- wb_req  out  1  level request to write back the current group's output.
- wb_ack  in  1  writeback accepted; deasserts wb_req next cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; group counter 0; address accumulator 0.
- Config latch: on accepted start, latch cfg_* into internal registers. cc_* outputs are driven only from the latched copies, so cfg_* may change while busy.
- Illegal config: cfg_ci_groups==0, cfg_co_groups==0, or cfg_co_groups>2^BIAS_ADDR_WIDTH.
  - Set cfg_err, pulse done in the cycle after start, busy high for exactly that one cycle.
  - No cc_go, in_rewind or wb_req is issued.
- Address arithmetic: cc_wt_base_addr = cfg_wt_base + og*cfg_ci_groups, computed incrementally (accumulator += ci_groups per group). No multiplier. Wraps modulo 2^WT_ADDR_WIDTH; wrap is not an error.
- States:
  - IDLE: start -> SETUP; busy<=1; cfg_err<=0; og<=0; acc<=cfg_wt_base.
  - SETUP: drive cc_output_group<=og, cc_wt_base_addr<=acc; pulse in_rewind -> REWIND.
  - REWIND: wait in_rewind_ack (may already be high) -> LAUNCH.
  - LAUNCH: only if cc_busy==0, pulse cc_go -> RUN. Otherwise hold.
  - RUN: wait cc_done -> WB. A cc_done arriving before RUN is ignored.
  - WB: wb_req=1 until wb_ack sampled high.
    - If og==co_groups-1 -> FIN.
    - Else og<=og+1, acc<=acc+ci_groups -> SETUP.
  - FIN: done=1 for one cycle, busy<=0 -> IDLE.
- Latency: start to first cc_go is at least 3 cycles (SETUP, REWIND with ack already high, LAUNCH).
- Group ordering: cc_output_group/cc_wt_base_addr are stable from SETUP through the end of RUN. They update only in the WB->SETUP transition, never while cc_busy.
- Simultaneous events:
  - start while busy: ignored.
  - abort in any non-IDLE state: next cycle state=IDLE, busy=0, wb_req=0, no done pulse, cfg_err unchanged. The downstream conv controller is not stopped by this block.
  - rst mid-layer: identical to reset values.
  - wb_ack while wb_req low: ignored.
  - cc_done and abort in the same cycle: abort wins.

Optional Feature:
- Macro: CONV_SCHED_PERF_EN.
- Defined: adds outputs perf_cycles[31:0] and perf_wb_stall[31:0].
  - perf_cycles counts cycles with busy high.
  - perf_wb_stall counts WB cycles with wb_ack low.
  - Both clear on accepted start, hold after done/abort, saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ci=4, co=3, wt_base=0x100, acks immediate, cc_done 20 cycles after go -> 3 cc_go pulses with (group, addr) = (0,0x100), (1,0x104), (2,0x108); 3 in_rewind, 3 wb_req; single done; busy falls with done.
- ci=0 -> cfg_err=1, done the cycle after start, no cc_go/in_rewind/wb_req; next legal start clears cfg_err.
- ci=0x300, co=8, wt_base=0xF00 (12-bit) -> group 1 addr 0x200 (wrap), group 7 addr 0x400.
- wb_ack held low 50 cycles on group 0 -> wb_req stays high, no group-1 in_rewind until ack; with CONV_SCHED_PERF_EN, perf_wb_stall=50.
- abort asserted in RUN of group 1 while cc_done pulses same cycle -> IDLE next cycle, no wb_req, no done; start re-issued during abort cycle is ignored.
- cc_busy held high entering LAUNCH for 10 cycles -> cc_go delayed exactly until the first cycle cc_busy is low; start pulsed while busy -> no effect.
